// File: rtl/fetch_pipe_ctrl.sv
// fetch_pipe_ctrl: PC, imem handshake and IF/ID register driven by hazard stall and EX redirect decisions
module fetch_pipe_ctrl #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hz_stall,
  input  logic             ex_redirect,
  input  logic [XLEN-1:0]  ex_target,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [XLEN-1:0]  imem_rdata,
  input  logic             imem_ready,
  output logic             ifid_valid,
  output logic [XLEN-1:0]  ifid_instr,
  output logic [XLEN-1:0]  ifid_pc,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic {FETCH, DROP} state_t;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);
  state_t state;
  logic [XLEN-1:0] pc, tgt;
  logic [XLEN-1:0] tgt_in;
  assign tgt_in = ex_target & ~XLEN'(3);
  assign imem_req = rst_n;
  assign imem_addr = pc;
  assign idex_bubble = hz_stall | ex_redirect;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      pc <= RESET_PC;
      tgt <= '0;
      ifid_valid <= 1'b0;
      ifid_instr <= NOP;
      ifid_pc <= '0;
    end else if (state == FETCH) begin
      if (ex_redirect) begin
        ifid_valid <= 1'b0;
        ifid_instr <= NOP;
        if (imem_ready) pc <= tgt_in;
        else begin
          tgt <= tgt_in;
          state <= DROP;
        end
      end else if (hz_stall) begin
        pc <= pc;
      end else if (imem_ready) begin
        ifid_valid <= 1'b1;
        ifid_instr <= imem_rdata;
        ifid_pc <= pc;
        pc <= pc + XLEN'(4);
      end else begin
        ifid_valid <= 1'b0;
      end
    end else begin
      // the old-pc response is discarded; only the target survives
      if (ex_redirect) tgt <= tgt_in;
      if (imem_ready) begin
        pc <= ex_redirect ? tgt_in : tgt;
        state <= FETCH;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hz_stall && !ex_redirect && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (ex_redirect && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// tb_fetch_pipe_ctrl: table-driven directed checks of the fetch controller
module tb_fetch_pipe_ctrl;
  logic clk = 0, rst_n = 0;
  logic hz_stall = 0, ex_redirect = 0, imem_ready = 0;
  logic [31:0] ex_target = 0, imem_rdata = 0;
  logic imem_req, ifid_valid, idex_bubble;
  logic [31:0] imem_addr, ifid_instr, ifid_pc;
  logic [3:0] stall_cnt, flush_cnt;
  int checks = 0, errors = 0;

  fetch_pipe_ctrl #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .hz_stall(hz_stall), .ex_redirect(ex_redirect),
    .ex_target(ex_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .ifid_valid(ifid_valid),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .idex_bubble(idex_bubble),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic stall, redir;
    logic [31:0] tgt;
    logic ready;
    logic [31:0] rdata, addr;
    logic bubble, valid;
    logic [31:0] instr, pc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] t, input logic rdy, input logic [31:0] d);
    hz_stall = s; ex_redirect = r; ex_target = t; imem_ready = rdy; imem_rdata = d;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " imem_req"}, 32'(imem_req), 0);
    chk({tag, " imem_addr"}, imem_addr, 0);
    chk({tag, " ifid_valid"}, 32'(ifid_valid), 0);
    chk({tag, " ifid_instr"}, ifid_instr, 32'h13);
    chk({tag, " ifid_pc"}, ifid_pc, 0);
    chk({tag, " stall_cnt"}, 32'(stall_cnt), 0);
    chk({tag, " flush_cnt"}, 32'(flush_cnt), 0);
  endtask

  vec_t v[21];

  initial begin
    //      stall redir tgt       rdy rdata       addr      bub val instr        pc
    v[0]  = '{0, 0, 32'h0,   1, 32'h100, 32'h0,   0, 1, 32'h100, 32'h0};
    v[1]  = '{0, 0, 32'h0,   1, 32'h104, 32'h4,   0, 1, 32'h104, 32'h4};
    v[2]  = '{0, 0, 32'h0,   1, 32'h108, 32'h8,   0, 1, 32'h108, 32'h8};
    v[3]  = '{0, 0, 32'h0,   1, 32'h10C, 32'hC,   0, 1, 32'h10C, 32'hC};
    v[4]  = '{1, 0, 32'h0,   1, 32'h110, 32'h10,  1, 1, 32'h10C, 32'hC};
    v[5]  = '{1, 0, 32'h0,   1, 32'h110, 32'h10,  1, 1, 32'h10C, 32'hC};
    v[6]  = '{0, 0, 32'h0,   1, 32'h110, 32'h10,  0, 1, 32'h110, 32'h10};
    v[7]  = '{0, 1, 32'h203, 1, 32'h114, 32'h14,  1, 0, 32'h0,   32'h0};
    v[8]  = '{0, 0, 32'h0,   1, 32'h300, 32'h200, 0, 1, 32'h300, 32'h200};
    v[9]  = '{0, 1, 32'h8,   1, 32'h304, 32'h204, 1, 0, 32'h0,   32'h0};
    v[10] = '{0, 0, 32'h0,   0, 32'h0,   32'h8,   0, 0, 32'h0,   32'h0};
    v[11] = '{0, 1, 32'h40,  0, 32'hDEAD,32'h8,   1, 0, 32'h0,   32'h0};
    v[12] = '{0, 0, 32'h0,   0, 32'hDEAD,32'h8,   0, 0, 32'h0,   32'h0};
    v[13] = '{1, 0, 32'h0,   0, 32'hDEAD,32'h8,   1, 0, 32'h0,   32'h0};
    v[14] = '{0, 0, 32'h0,   1, 32'hBAD, 32'h8,   0, 0, 32'h0,   32'h0};
    v[15] = '{0, 0, 32'h0,   1, 32'h140, 32'h40,  0, 1, 32'h140, 32'h40};
    v[16] = '{1, 1, 32'h80,  1, 32'h144, 32'h44,  1, 0, 32'h0,   32'h0};
    v[17] = '{0, 0, 32'h0,   1, 32'h180, 32'h80,  0, 1, 32'h180, 32'h80};
    v[18] = '{0, 1, 32'h100, 0, 32'h0,   32'h84,  1, 0, 32'h0,   32'h0};
    v[19] = '{0, 1, 32'h120, 1, 32'hBAD, 32'h84,  1, 0, 32'h0,   32'h0};
    v[20] = '{0, 0, 32'h0,   1, 32'h220, 32'h120, 0, 1, 32'h220, 32'h120};

    #12 check_reset_state("reset");
    @(posedge clk); #1 rst_n = 1;
    #1 chk("req after reset", 32'(imem_req), 1);

    for (int i = 0; i < 21; i++) begin
      drive(v[i].stall, v[i].redir, v[i].tgt, v[i].ready, v[i].rdata);
      #2;
      chk($sformatf("v%0d imem_addr", i), imem_addr, v[i].addr);
      chk($sformatf("v%0d idex_bubble", i), 32'(idex_bubble), 32'(v[i].bubble));
      @(posedge clk); #1;
      chk($sformatf("v%0d ifid_valid", i), 32'(ifid_valid), 32'(v[i].valid));
      if (v[i].valid) begin
        chk($sformatf("v%0d ifid_instr", i), ifid_instr, v[i].instr);
        chk($sformatf("v%0d ifid_pc", i), ifid_pc, v[i].pc);
      end else if (v[i].redir) begin
        chk($sformatf("v%0d ifid_instr nop", i), ifid_instr, 32'h13);
      end
      if (i == 5) chk("stall_cnt after 2 stalls", 32'(stall_cnt), 2);
      if (i == 7) chk("flush_cnt after first redirect", 32'(flush_cnt), 1);
    end
    chk("stall_cnt after table", 32'(stall_cnt), 3);
    chk("flush_cnt after table", 32'(flush_cnt), 6);

    // saturation of stall counter; pc must stay on 0x124
    drive(1, 0, 0, 1, 32'h777);
    repeat (14) @(posedge clk);
    #1;
    chk("stall_cnt saturated", 32'(stall_cnt), 15);
    chk("addr held in stall", imem_addr, 32'h124);
    chk("ifid held in stall", ifid_instr, 32'h220);
    drive(0, 1, 32'h124, 1, 32'h777);
    repeat (12) @(posedge clk);
    #1;
    chk("flush_cnt saturated", 32'(flush_cnt), 15);
    chk("stall_cnt held at max", 32'(stall_cnt), 15);

    // enter DROP, then reset asynchronously between edges
    drive(0, 1, 32'h500, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    #3 rst_n = 0;
    #1 check_reset_state("async reset");
    @(posedge clk); #1 rst_n = 1;
    drive(0, 0, 0, 1, 32'h555);
    #2 chk("post-reset addr", imem_addr, 0);
    @(posedge clk); #1;
    chk("post-reset ifid_valid", 32'(ifid_valid), 1);
    chk("post-reset ifid_instr", ifid_instr, 32'h555);
    chk("post-reset ifid_pc", ifid_pc, 0);
    chk("post-reset next addr", imem_addr, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
